// File: rtl/msb_word_serializer_if.sv
// Word-in / bit-out bundle between the upstream feeder and msb_word_serializer.
// The slave modport is the serializer's view; master is the producer/consumer side.
interface msb_word_serializer_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] Data;
  logic             Load;
  logic             Ready;
  logic             String;
  logic             Bit_Valid;
  logic             Last_Bit;
  logic             Div_Clear;
  logic             Done;

  modport slave (
    input  Data, Load,
    output Ready, String, Bit_Valid, Last_Bit, Div_Clear, Done
  );

  modport master (
    output Data, Load,
    input  Ready, String, Bit_Valid, Last_Bit, Div_Clear, Done
  );
endinterface

// File: rtl/msb_word_serializer.sv
// Serializes a parallel word MSB-first for the divisibility-by-7 checker, preceded by a clear pulse.
// Optional: define SKIP_LEADING_ZEROS_EN to drop leading zero bits (a zero word still sends one bit).
module msb_word_serializer #(
  parameter int WIDTH = 8
) (
  input logic                  Clock,
  input logic                  Reset,
  msb_word_serializer_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_string;
  logic             r_bit_valid;
  logic             r_last_bit;
  logic             r_div_clear;
  logic             r_done;

  logic [WIDTH-1:0] w_sh_init;
  logic [CNT_W-1:0] w_cnt_init;

`ifdef SKIP_LEADING_ZEROS_EN
  // Starting the counter at lz makes the LSB land on LAST_CNT; a zero word degenerates to one bit.
  logic [CNT_W-1:0] w_lz;
  always_comb begin
    w_lz = LAST_CNT;
    for (int unsigned i = 0; i < WIDTH; i++)
      if (bus.Data[i]) w_lz = CNT_W'(WIDTH - 1 - i);
  end
  assign w_cnt_init = w_lz;
  assign w_sh_init  = bus.Data << w_lz;
`else
  assign w_cnt_init = '0;
  assign w_sh_init  = bus.Data;
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_ready     <= 1'b1;
      r_string    <= 1'b0;
      r_bit_valid <= 1'b0;
      r_last_bit  <= 1'b0;
      r_div_clear <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Load && r_ready) begin
            r_shreg     <= w_sh_init;
            r_cnt       <= w_cnt_init;
            r_ready     <= 1'b0;
            r_div_clear <= 1'b1;
            r_state     <= S_CLEAR;
          end
        end
        // CLEAR and SHIFT share the bit-emit path; outputs lead the state by one edge.
        S_CLEAR, S_SHIFT: begin
          if (r_state == S_SHIFT && r_last_bit) begin
            r_string    <= 1'b0;
            r_bit_valid <= 1'b0;
            r_last_bit  <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_div_clear <= 1'b0;
            r_string    <= r_shreg[WIDTH-1];
            r_bit_valid <= 1'b1;
            r_shreg     <= {r_shreg[WIDTH-2:0], 1'b0};
            r_last_bit  <= (r_cnt == LAST_CNT);
            if (r_cnt != LAST_CNT) r_cnt <= r_cnt + 1'b1;
            r_state     <= S_SHIFT;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Ready     = r_ready;
  assign bus.String    = r_string;
  assign bus.Bit_Valid = r_bit_valid;
  assign bus.Last_Bit  = r_last_bit;
  assign bus.Div_Clear = r_div_clear;
  assign bus.Done      = r_done;
endmodule

// File: tb/tb_msb_word_serializer.sv
// Bench for msb_word_serializer: vector table driven through the handshake, cycle-stamped
// scoreboard of expected outputs, serial mod-7 reconstruction checked at each Done.
module tb_msb_word_serializer;
  localparam int WIDTH = 8;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  msb_word_serializer_if #(.WIDTH(WIDTH)) bus ();
  msb_word_serializer #(.WIDTH(WIDTH)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

  typedef struct {
    int   cyc;
    logic clr, bv, str, last, done;
  } ev_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               rem;
    bit               hold;
    bit               poke;
  } vec_t;

  ev_t  exp_q[$];
  int   rem_q[$];
  vec_t vecs[10];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ready_lo = 0;
  int   ready_from = 0;
  bit   mon_en = 1'b0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int word_bits(input logic [WIDTH-1:0] d);
    int n;
`ifdef SKIP_LEADING_ZEROS_EN
    n = 1;
    for (int i = 0; i < WIDTH; i++) if (d[i]) n = i + 1;
`else
    n = WIDTH + 0 * int'(d[0]);
`endif
    return n;
  endfunction

  // Push Div_Clear at k, then up to 'limit' bits at k+1.., then Done if the word completes.
  task automatic push_word(input logic [WIDTH-1:0] d, input int k, input int limit);
    int n;
    ev_t e;
    n = word_bits(d);
    e = '{cyc: k, clr: 1'b1, bv: 1'b0, str: 1'b0, last: 1'b0, done: 1'b0};
    exp_q.push_back(e);
    for (int i = 0; i < n && i < limit; i++) begin
      e = '{cyc: k + 1 + i, clr: 1'b0, bv: 1'b1, str: d[n-1-i], last: (i == n - 1), done: 1'b0};
      exp_q.push_back(e);
    end
    if (limit >= n) begin
      e = '{cyc: k + 1 + n, clr: 1'b0, bv: 1'b0, str: 1'b0, last: 1'b0, done: 1'b1};
      exp_q.push_back(e);
      ready_lo   = k;
      ready_from = k + 2 + n;
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (bus.Ready !== 1'b1 && t < 200) begin
      @(negedge Clock);
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got %0b expected 1", bus.Ready);
    end
  endtask

  task automatic send(input vec_t v);
    int k;
    wait_ready();
    bus.Data = v.data;
    bus.Load = 1'b1;
    k = cyc + 1;
    push_word(v.data, k, WIDTH);
    rem_q.push_back(v.rem);
    @(negedge Clock);
    bus.Data = ~v.data;
    if (!v.hold) bus.Load = 1'b0;
    if (v.poke) begin
      repeat (3) @(negedge Clock);
      bus.Load = 1'b1;
      @(negedge Clock);
      bus.Load = 1'b0;
    end
  endtask

  // Monitor: every cycle either matches the next stamped event or shows quiet outputs.
  int  acc = 0;
  ev_t cur;
  initial forever begin
    @(negedge Clock);
    if (mon_en) begin
      if (Reset)
        chk("ready", bus.Ready, (cyc >= ready_lo && cyc < ready_from) ? 0 : 1);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        cur = exp_q.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL missed_event: expected at cycle %0d, now %0d", cur.cyc, cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        cur = exp_q.pop_front();
        chk("div_clear", bus.Div_Clear, cur.clr);
        chk("bit_valid", bus.Bit_Valid, cur.bv);
        chk("string", bus.String, cur.str);
        chk("last_bit", bus.Last_Bit, cur.last);
        chk("done", bus.Done, cur.done);
      end else begin
        chk("quiet_outputs", {bus.Div_Clear, bus.Bit_Valid, bus.Last_Bit, bus.Done, bus.String}, 0);
      end
      if (bus.Div_Clear === 1'b1) acc = 0;
      if (bus.Bit_Valid === 1'b1) acc = (2 * acc + int'(bus.String)) % 7;
      if (bus.Done === 1'b1) begin
        if (rem_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got remainder %0d with no word pending", acc);
        end else begin
          chk("remainder", acc, rem_q.pop_front());
        end
      end
    end
  end

  initial begin
    int k;
    int t;
    vecs[0] = '{data: 8'h62, rem: 0, hold: 1'b0, poke: 1'b0};
    vecs[1] = '{data: 8'hFF, rem: 3, hold: 1'b0, poke: 1'b0};
    vecs[2] = '{data: 8'h62, rem: 0, hold: 1'b0, poke: 1'b1};
    vecs[3] = '{data: 8'h07, rem: 0, hold: 1'b1, poke: 1'b0};
    vecs[4] = '{data: 8'h08, rem: 1, hold: 1'b0, poke: 1'b0};
    vecs[5] = '{data: 8'h05, rem: 5, hold: 1'b0, poke: 1'b0};
    vecs[6] = '{data: 8'h00, rem: 0, hold: 1'b0, poke: 1'b0};
    vecs[7] = '{data: 8'hA5, rem: 4, hold: 1'b0, poke: 1'b0};
    vecs[8] = '{data: 8'h80, rem: 2, hold: 1'b0, poke: 1'b0};
    vecs[9] = '{data: 8'h01, rem: 1, hold: 1'b0, poke: 1'b0};

    // Reset with Load asserted: reset must win.
    bus.Data = '0;
    bus.Load = 1'b1;
    Reset    = 1'b0;
    repeat (2) @(negedge Clock);
    chk("rst_ready", bus.Ready, 1);
    chk("rst_string", bus.String, 0);
    chk("rst_bit_valid", bus.Bit_Valid, 0);
    chk("rst_last_bit", bus.Last_Bit, 0);
    chk("rst_div_clear", bus.Div_Clear, 0);
    chk("rst_done", bus.Done, 0);
    bus.Load = 1'b0;
    Reset    = 1'b1;
    @(negedge Clock);
    chk("post_rst_ready", bus.Ready, 1);
    chk("post_rst_div_clear", bus.Div_Clear, 0);
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) send(vecs[i]);

    // Abort 0x62 with Reset low while its 4th bit is on String.
    wait_ready();
    bus.Data = 8'h62;
    bus.Load = 1'b1;
    k = cyc + 1;
    push_word(8'h62, k, 4);
    ready_lo   = k;
    ready_from = k + 5;
    @(negedge Clock);
    bus.Load = 1'b0;
    repeat (4) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk("abort_ready", bus.Ready, 1);
    chk("abort_bit_valid", bus.Bit_Valid, 0);
    chk("abort_string", bus.String, 0);
    chk("abort_last_bit", bus.Last_Bit, 0);
    chk("abort_done", bus.Done, 0);
    Reset = 1'b1;
    repeat (WIDTH + 4) @(negedge Clock);

    // Word after the abort must run normally.
    send('{data: 8'h62, rem: 0, hold: 1'b0, poke: 1'b0});

    t = 0;
    while ((exp_q.size() > 0 || rem_q.size() > 0) && t < 200) begin
      @(negedge Clock);
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d events pending expected 0", exp_q.size());
    end
    repeat (3) @(negedge Clock);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
